uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among NUM_REQ byte-producing clients using round-robin arbitration.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bus between the byte-producing clients, the shared UART transmitter and
// the round-robin arbiter that multiplexes them.
//   master : client/UART side (drives req, req_data, tx_done)
//   slave  : arbiter side (drives ack, grant_id, busy, trmt, tx_data, timeout_err)
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 trmt;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 timeout_err;

  modport master (
    output req, req_data, tx_done,
    input  ack, grant_id, busy, trmt, tx_data, timeout_err
  );

  modport slave (
    input  req, req_data, tx_done,
    output ack, grant_id, busy, trmt, tx_data, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ clients.
// Grants a client, latches its byte, strobes trmt for one cycle, waits for
// the UART's tx_done, acks the client and rotates priority past it.
// Optional build macro UART_ARB_TIMEOUT_EN: bounds the wait for tx_done to
// TIMEOUT_CYCLES, aborting with an ack and a sticky timeout_err.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 30000
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_ACK} state_t;

  state_t                   state;
  logic [NUM_REQ-1:0]       ack_q;
  logic                     trmt_q;
  logic                     busy_q;
  logic [7:0]               tx_data_q;
  logic [IDW-1:0]           grant_q;
  logic [IDW-1:0]           rr_ptr;
  logic                     done_armed;
  logic [NUM_REQ-1:0][7:0]  req_bytes;
  logic [NUM_REQ-1:0]       ack_onehot;
  logic [IDW-1:0]           rr_next;
  logic [IDW-1:0]           win;
  logic                     found;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]         wait_cnt;
  logic                     timeout_q;
`endif

  assign req_bytes  = bus.req_data;
  assign ack_onehot = NUM_REQ'(1) << grant_q;
  assign rr_next    = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // First pending request scanning upward from rr_ptr, wrapping at NUM_REQ
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Transfer FSM; every bus output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ack_q      <= '0;
      trmt_q     <= 1'b0;
      busy_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_q    <= '0;
      rr_ptr     <= '0;
      done_armed <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      ack_q  <= '0;
      trmt_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_q   <= win;
            tx_data_q <= req_bytes[win];
            trmt_q    <= 1'b1;
            busy_q    <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // tx_done still shows the previous frame here; it only counts once
          // it has been seen low inside WAIT
          done_armed <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.tx_done) done_armed <= 1'b1;
          if (bus.tx_done && done_armed) begin
            ack_q <= ack_onehot;
            state <= S_ACK;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            ack_q     <= ack_onehot;
            timeout_q <= 1'b1;
            state     <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_ACK: begin
          rr_ptr <= rr_next;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
  assign bus.trmt     = trmt_q;
  assign bus.tx_data  = tx_data_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4); the bench plays both the
// clients and the UART transmitter's tx_done flag.
module tb_uart_tx_arbiter;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO         = 100;
  localparam int SINGLE_LEN = 60;
`else
  localparam int TO         = 30000;
  localparam int SINGLE_LEN = 26050;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transfer, entered in an IDLE cycle with req[id] already raised.
  task automatic xfer(input int id, input logic [7:0] d, input int len,
                      input bit drop_at_ack, input bit rearm,
                      input bit early_drop, input bit scramble);
    int n;
    bit bad;
    n = 0;
    while (!bus.trmt && n < 8) begin tick(); n++; end
    chk("trmt_lat", n, 1);
    chk("grant_id", bus.grant_id, id);
    chk("tx_data", bus.tx_data, d);
    chk("busy", bus.busy, 1);
    if (early_drop) bus.req[id] = 1'b0;
    if (scramble) bus.req_data[8*id +: 8] = ~d;
    tick();
    bus.tx_done = 1'b0;
    chk("trmt_1cyc", bus.trmt, 0);
    bad = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (bus.ack != 4'b0 || bus.trmt) bad = 1'b1;
      tick();
    end
    if (bus.ack != 4'b0) bad = 1'b1;
    chk("quiet_wait", bad, 0);
    bus.tx_done = 1'b1;
    tick();
    chk("ack", bus.ack, 32'(1) << id);
    chk("tx_data_hold", bus.tx_data, d);
    if (drop_at_ack) bus.req[id] = 1'b0;
    tick();
    chk("ack_1cyc", bus.ack, 0);
    chk("idle_busy", bus.busy, 0);
    if (rearm) bus.req[id] = 1'b1;
  endtask

  initial begin
    int n;
    bit bad;
    tests        = 0;
    fails        = 0;
    rst          = 1'b1;
    bus.req      = 4'b0;
    bus.req_data = '0;
    bus.tx_done  = 1'b1;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_trmt", bus.trmt, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_terr", bus.timeout_err, 0);
    rst = 1'b0;

    // Reset while waiting for tx_done: transfer abandoned, no ack
    bus.req_data = 32'h3C00_0000;
    bus.req      = 4'b1000;
    n = 0;
    while (!bus.trmt && n < 8) begin tick(); n++; end
    chk("r_trmt", bus.trmt, 1);
    chk("r_grant", bus.grant_id, 3);
    tick();
    bus.tx_done = 1'b0;
    tick();
    tick();
    rst     = 1'b1;
    bus.req = 4'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("r_busy", bus.busy, 0);
    chk("r_trmt0", bus.trmt, 0);
    chk("r_ack", bus.ack, 0);
    chk("r_grant0", bus.grant_id, 0);
    bus.tx_done = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ack != 4'b0 || bus.busy || bus.trmt) bad = 1'b1;
      tick();
    end
    chk("r_no_ack", bad, 0);

    // Round robin with all four held: 0,1,2,3,0
    bus.req_data = 32'h4433_2211;
    bus.req      = 4'b1111;
    xfer(0, 8'h11, 12, 1, 1, 0, 0);
    xfer(1, 8'h22, 12, 1, 1, 0, 0);
    xfer(2, 8'h33, 12, 1, 1, 0, 0);
    xfer(3, 8'h44, 12, 1, 1, 0, 0);
    xfer(0, 8'h11, 12, 1, 0, 0, 0);
    bus.req = 4'b0;

    // Single client 2, full-length frame; req_data changed after grant
    tick();
    bus.req_data = 32'h0000_0000;
    bus.req_data[23:16] = 8'hA5;
    bus.req = 4'b0100;
    xfer(2, 8'hA5, SINGLE_LEN, 1, 0, 0, 1);

    // rr_ptr now 3: req 0011 -> 0 then 1 (client 1 drops req mid-frame)
    bus.req_data = 32'h0000_5AC3;
    bus.req      = 4'b0011;
    xfer(0, 8'hC3, 20, 1, 0, 0, 0);
    xfer(1, 8'h5A, 20, 0, 0, 1, 0);
    bus.req = 4'b0;

    // Stale tx_done high at trmt (rr_ptr=2): ack only after the new rise
    tick();
    chk("stale_pre", bus.tx_done, 1);
    bus.req_data = 32'h00E7_0000;
    bus.req      = 4'b0100;
    xfer(2, 8'hE7, 8, 1, 0, 0, 0);

`ifdef UART_ARB_TIMEOUT_EN
    // tx_done never returns: abort 101 cycles after trmt, sticky error
    bus.req_data = 32'h0000_0096;
    bus.req      = 4'b0001;
    n = 0;
    while (!bus.trmt && n < 8) begin tick(); n++; end
    chk("to_trmt", bus.trmt, 1);
    n = 0;
    tick();
    n++;
    bus.tx_done = 1'b0;
    while (bus.ack == 4'b0 && n < 200) begin tick(); n++; end
    chk("to_lat", n, 101);
    chk("to_ack", bus.ack, 4'b0001);
    bus.req = 4'b0;
    tick();
    chk("to_err", bus.timeout_err, 1);
    bus.tx_done = 1'b1;
    bus.req_data = 32'h0000_6900;
    bus.req      = 4'b0010;
    xfer(1, 8'h69, 10, 1, 0, 0, 0);
    chk("to_sticky", bus.timeout_err, 1);
`else
    chk("terr_zero", bus.timeout_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
